// File: rtl/enc83_pkg.sv
// Shared constants, FSM state type and helpers for the registered 8-to-3 request encoder.
package enc83_pkg;

    localparam int unsigned N_LINES = 8;
    localparam int unsigned CODE_W  = 3;

    // Output-side FSM: StPresent means out_code holds a live request.
    typedef enum logic {
        StIdle    = 1'b0,
        StPresent = 1'b1
    } enc_state_e;

    // One-hot mask of a request index.
    function automatic logic [N_LINES-1:0] onehot8(input logic [CODE_W-1:0] code);
        return {{(N_LINES-1){1'b0}}, 1'b1} << code;
    endfunction

endpackage

// File: rtl/pri_sel8.sv
// Combinational 8-way first-set-bit search starting at a given index.
// mode=0 scans start, start+1, ... (mod 8); mode=1 scans start, start-1, ... (mod 8).
module pri_sel8
    import enc83_pkg::*;
(
    input  logic [N_LINES-1:0] req,
    input  logic [CODE_W-1:0]  start,
    input  logic               mode,
    output logic               found,
    output logic [CODE_W-1:0]  idx
);

    // Index visited at step i of the scan.
    function automatic logic [CODE_W-1:0] scan_at(input logic [CODE_W-1:0] s, input logic m,
                                                  input int i);
        return m ? (s - CODE_W'(i)) : (s + CODE_W'(i));
    endfunction

    // Walk the scan backwards so the earliest hit is the last assignment and wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N_LINES - 1; i >= 0; i--) begin
            if (req[scan_at(start, mode, i)]) begin
                found = 1'b1;
                idx   = scan_at(start, mode, i);
            end
        end
    end

endmodule

// File: rtl/encoder8_3_seq.sv
// Registered 8-to-3 request encoder: sticky pending set, one code per cycle on valid/ready.
module encoder8_3_seq
    import enc83_pkg::*;
#(
    parameter bit          PRIORITY_HIGH = 1'b1,
    parameter bit          ROUND_ROBIN   = 1'b0,
    parameter int unsigned CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [N_LINES-1:0] y,
    output logic [CODE_W-1:0]  out_code,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_LINES-1:0] pending,
    output logic               busy,
    output logic [CNT_W-1:0]   grant_cnt
);

    enc_state_e         state_q, state_d;
    logic [N_LINES-1:0] pending_q, pending_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [CODE_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               fire;
    logic               select;
    logic [N_LINES-1:0] cleared;
    logic               sel_found;
    logic [CODE_W-1:0]  sel_idx;
    logic [CODE_W-1:0]  sel_start;
    logic               sel_mode;

    // Round-robin scans upward from one past the last winner; fixed modes scan from an end.
    assign sel_start = ROUND_ROBIN ? (ptr_q + 3'd1) : (PRIORITY_HIGH ? 3'd7 : 3'd0);
    assign sel_mode  = !ROUND_ROBIN && PRIORITY_HIGH;

    pri_sel8 u_pri_sel8 (
        .req   (pending_q),
        .start (sel_start),
        .mode  (sel_mode),
        .found (sel_found),
        .idx   (sel_idx)
    );

    // Next-state: select a new winner when the output slot is free or being drained.
    always_comb begin
        fire    = (state_q == StPresent) && out_ready;
        select  = sel_found && ((state_q == StIdle) || out_ready);
        state_d = state_q;
        code_d  = code_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        cleared = '0;
        if (select) begin
            state_d = StPresent;
            code_d  = sel_idx;
            ptr_d   = sel_idx;
            cleared = onehot8(sel_idx);
        end else if (fire) begin
            state_d = StIdle;
        end
        if (fire) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Set applied after clear so a same-cycle re-request is queued again.
        pending_d = (pending_q & ~cleared) | (en ? y : '0);
    end

    // State registers; reset drops any presented code and parks the pointer at 7.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pending_q <= '0;
            code_q    <= '0;
            ptr_q     <= 3'd7;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_code  = code_q;
    assign out_valid = (state_q == StPresent);
    assign pending   = pending_q;
    assign busy      = out_valid | (|pending_q);
    assign grant_cnt = cnt_q;

endmodule
